// File: rtl/fir_wb_sequencer.sv
// Wishbone master that streams samples through a memory-mapped FIR core:
// programs the length, starts it, pushes each X, pulls each Y, then polls for ap_done.
module fir_wb_sequencer #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned POLL_MAX    = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [31:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        x_valid,
    output logic        x_ready,
    input  logic [31:0] x_data,
    output logic        y_valid,
    output logic [31:0] y_data,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i
);

    typedef enum logic [2:0] {
        IDLE, WR_LEN, WR_START, GET_X, WR_X, RD_Y, POLL, FINISH
    } state_t;

    localparam logic [31:0] OFF_CTRL = 32'h00;
    localparam logic [31:0] OFF_LEN  = 32'h10;
    localparam logic [31:0] OFF_X    = 32'h80;
    localparam logic [31:0] OFF_Y    = 32'h84;
    localparam logic [31:0] WAIT_LAST = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_MAX - 1);

    state_t      state, state_next;
    logic [31:0] len_q, x_q, sample_cnt, wait_cnt, poll_cnt;

    logic        bus_state, launch, acked, timeout, poll_abort, accept, x_fire;
    logic        req_we;
    logic [31:0] req_adr, req_dat;

    // Ack only counts while a cycle is open; a stray ack with cyc low is ignored.
    assign acked   = m_cyc_o & m_ack_i;
    assign timeout = m_cyc_o & ~m_ack_i & (wait_cnt == WAIT_LAST);
    assign launch  = bus_state & ~m_cyc_o;
    assign x_ready = (state == GET_X);
    assign x_fire  = x_ready & x_valid;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        bus_state  = 1'b0;
        req_we     = 1'b0;
        req_adr    = BASE_ADDR + OFF_CTRL;
        req_dat    = '0;
        accept     = 1'b0;
        poll_abort = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (len == '0) ? FINISH : WR_LEN;
                end
            end
            WR_LEN: begin
                bus_state = 1'b1;
                req_we    = 1'b1;
                req_adr   = BASE_ADDR + OFF_LEN;
                req_dat   = len_q;
                if (acked) state_next = WR_START;
            end
            WR_START: begin
                bus_state = 1'b1;
                req_we    = 1'b1;
                req_dat   = 32'h1;
                if (acked) state_next = GET_X;
            end
            GET_X: begin
                if (x_fire) state_next = WR_X;
            end
            WR_X: begin
                bus_state = 1'b1;
                req_we    = 1'b1;
                req_adr   = BASE_ADDR + OFF_X;
                req_dat   = x_q;
                if (acked) state_next = RD_Y;
            end
            RD_Y: begin
                bus_state = 1'b1;
                req_adr   = BASE_ADDR + OFF_Y;
                // sample_cnt never exceeds len_q-1 here, so the +1 cannot wrap.
                if (acked) state_next = (sample_cnt + 32'd1 != len_q) ? GET_X : POLL;
            end
            POLL: begin
                bus_state = 1'b1;
                if (acked) begin
                    if (m_dat_i[1]) begin
                        state_next = FINISH;
                    end else if (poll_cnt == POLL_LAST) begin
                        poll_abort = 1'b1;
                        state_next = FINISH;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout) state_next = FINISH;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            y_valid    <= 1'b0;
            y_data     <= '0;
            len_q      <= '0;
            x_q        <= '0;
            sample_cnt <= '0;
            poll_cnt   <= '0;
            wait_cnt   <= '0;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_sel_o    <= '0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
        end else begin
            state   <= state_next;
            done    <= (state == FINISH);
            y_valid <= (state == RD_Y) && acked;

            if (accept) begin
                len_q      <= len;
                sample_cnt <= '0;
                poll_cnt   <= '0;
                err        <= 1'b0;
                busy       <= 1'b1;
            end
            if (state == FINISH) busy <= 1'b0;
            if (timeout || poll_abort) err <= 1'b1;

            if (x_fire) x_q <= x_data;
            if ((state == RD_Y) && acked) begin
                y_data     <= m_dat_i;
                sample_cnt <= sample_cnt + 32'd1;
            end
            if ((state == POLL) && acked) poll_cnt <= poll_cnt + 32'd1;

            // One classic cycle per state visit: open the cycle after entry, close on ack or timeout.
            if (launch) begin
                m_cyc_o  <= 1'b1;
                m_stb_o  <= 1'b1;
                m_we_o   <= req_we;
                m_sel_o  <= 4'hF;
                m_adr_o  <= req_adr;
                m_dat_o  <= req_dat;
                wait_cnt <= '0;
            end else if (acked || timeout) begin
                m_cyc_o <= 1'b0;
                m_stb_o <= 1'b0;
                m_we_o  <= 1'b0;
            end else if (m_cyc_o) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fir_wb_sequencer.sv
// Directed bench for fir_wb_sequencer: a small Wishbone slave model logs every
// transfer, and expected bus/Y sequences come from hand-written tables.
module tb_fir_wb_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;

    typedef struct {
        logic        we;
        logic [31:0] off;
        logic [31:0] dat;
    } bus_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] len = '0;
    logic        busy, done, err;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic [31:0] x_data;
    logic        y_valid;
    logic [31:0] y_data;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic        m_ack_i;

    fir_wb_sequencer dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .len(len),
        .busy(busy), .done(done), .err(err),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_data(y_data),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
    );

    always #5 clk = ~clk;

    // ---------------- slave / source models ----------------
    logic        ack_en = 1'b1;
    logic        stall_en = 1'b0;
    logic [31:0] stall_off = '0;
    int unsigned poll_target = 0;
    int unsigned poll_seen = 0;
    int unsigned x_idx = 0;
    int unsigned cyc_num = 0;
    logic [31:0] last_x = '0;

    assign x_data  = 32'(x_idx + 1);
    assign m_ack_i = m_cyc_o & m_stb_o & ack_en & ~(stall_en && (m_adr_o == BASE + stall_off));
    assign m_dat_i = (m_adr_o == BASE + 32'h84) ? last_x * 32'd10 :
                     (m_adr_o == BASE)          ? ((poll_seen >= poll_target) ? 32'h2 : 32'h0) :
                                                  32'h0;

    always @(posedge clk) begin
        cyc_num <= cyc_num + 1;
        if (x_valid && x_ready) x_idx <= x_idx + 1;
        if (m_cyc_o && m_ack_i && m_we_o && m_adr_o == BASE + 32'h80) last_x <= m_dat_o;
        if (m_cyc_o && m_ack_i && !m_we_o && m_adr_o == BASE) poll_seen <= poll_seen + 1;
    end

    // ---------------- monitors (sampled on the falling edge) ----------------
    bus_vec_t    log_q[$];
    int unsigned log_cyc[$];
    logic [31:0] y_q[$];
    int unsigned done_cnt = 0, cyc_hi = 0, proto_err = 0;
    logic        prev_cyc = 1'b0;
    logic [64:0] prev_bus = '0;

    always @(negedge clk) begin
        if (m_cyc_o && m_stb_o && m_ack_i) begin
            log_q.push_back('{m_we_o, m_adr_o - BASE, m_we_o ? m_dat_o : m_dat_i});
            log_cyc.push_back(cyc_num);
        end
        if (y_valid) y_q.push_back(y_data);
        if (done) done_cnt <= done_cnt + 1;
        if (m_cyc_o) cyc_hi <= cyc_hi + 1;
        if (m_stb_o !== m_cyc_o) proto_err <= proto_err + 1;
        if (m_cyc_o && m_sel_o != 4'hF) proto_err <= proto_err + 1;
        if (m_cyc_o && prev_cyc && {m_we_o, m_adr_o, m_dat_o} != prev_bus) proto_err <= proto_err + 1;
        prev_cyc <= m_cyc_o;
        prev_bus <= {m_we_o, m_adr_o, m_dat_o};
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic pulse_start(input logic [31:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_bus(input string name, input logic [31:0] off, input logic we, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (m_cyc_o && m_adr_o == BASE + off && m_we_o == we) seen = 1;
        end
        check({name, "_bus_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic check_bus(input string name, input int base, input int idx, input bus_vec_t e);
        if (base + idx < log_q.size()) begin
            check($sformatf("%s_bus%0d", name, idx),
                  {31'd0, log_q[base + idx].we, log_q[base + idx].off},
                  {31'd0, e.we, e.off});
            check($sformatf("%s_dat%0d", name, idx), 64'(log_q[base + idx].dat), 64'(e.dat));
        end
    endtask

    // ---------------- test sequence ----------------
    bus_vec_t    exp_a[9];
    bus_vec_t    exp_d[9];
    bus_vec_t    exp_e[7];
    logic [31:0] y_exp_a[3];

    initial begin
        int lb, yb, db, cb, lat;

        exp_a = '{'{1'b1, 32'h10, 32'd3}, '{1'b1, 32'h00, 32'd1},
                  '{1'b1, 32'h80, 32'd1}, '{1'b0, 32'h84, 32'd10},
                  '{1'b1, 32'h80, 32'd2}, '{1'b0, 32'h84, 32'd20},
                  '{1'b1, 32'h80, 32'd3}, '{1'b0, 32'h84, 32'd30},
                  '{1'b0, 32'h00, 32'd2}};
        y_exp_a = '{32'd10, 32'd20, 32'd30};
        exp_d = '{'{1'b1, 32'h10, 32'd1}, '{1'b1, 32'h00, 32'd1},
                  '{1'b1, 32'h80, 32'd4}, '{1'b0, 32'h84, 32'd40},
                  '{1'b0, 32'h00, 32'd0}, '{1'b0, 32'h00, 32'd0},
                  '{1'b0, 32'h00, 32'd0}, '{1'b0, 32'h00, 32'd0},
                  '{1'b0, 32'h00, 32'd2}};
        exp_e = '{'{1'b1, 32'h10, 32'd2}, '{1'b1, 32'h00, 32'd1},
                  '{1'b1, 32'h80, 32'd5}, '{1'b0, 32'h84, 32'd50},
                  '{1'b1, 32'h80, 32'd6}, '{1'b0, 32'h84, 32'd60},
                  '{1'b0, 32'h00, 32'd2}};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        x_valid = 1'b1;
        @(negedge clk);
        #1;
        check("reset_ctrl", 64'({busy, done, err, x_ready, y_valid, m_cyc_o, m_stb_o, m_we_o}), 64'd0);
        check("reset_adr_dat", {m_adr_o, m_dat_o}, 64'd0);
        check("reset_sel_y", 64'({m_sel_o, y_data}), 64'd0);

        // Three-sample run, immediate ack, status done on first poll
        lb = log_q.size(); yb = y_q.size(); db = done_cnt;
        pulse_start(32'd3);
        check("a_busy", 64'(busy), 64'd1);
        wait_done("a", 200);
        check("a_nbus", 64'(log_q.size() - lb), 64'd9);
        for (int i = 0; i < 9; i++) check_bus("a", lb, i, exp_a[i]);
        check("a_ny", 64'(y_q.size() - yb), 64'd3);
        for (int i = 0; i < 3; i++)
            if (yb + i < y_q.size()) check($sformatf("a_y%0d", i), 64'(y_q[yb + i]), 64'(y_exp_a[i]));
        check("a_done_cnt", 64'(done_cnt - db), 64'd1);
        check("a_err_busy", 64'({err, busy}), 64'd0);

        // Zero length: done two cycles after start, no bus traffic
        cb = cyc_hi; lat = 0;
        @(negedge clk);
        start = 1'b1;
        len   = 32'd0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) lat = k;
        end
        check("zero_latency", 64'(lat), 64'd2);
        @(negedge clk);
        #1;
        check("zero_no_cyc", 64'(cyc_hi - cb), 64'd0);

        // Slave never acks the length write: abort after 255 wait cycles
        ack_en = 1'b0;
        cb = cyc_hi; db = done_cnt; lb = log_q.size();
        pulse_start(32'd5);
        wait_done("tmo", 400);
        check("tmo_cyc_cycles", 64'(cyc_hi - cb), 64'd255);
        check("tmo_err_busy", 64'({err, busy, m_cyc_o}), 64'b100);
        check("tmo_done_cnt", 64'(done_cnt - db), 64'd1);
        check("tmo_nbus", 64'(log_q.size() - lb), 64'd0);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", 64'(err), 64'd1);
        ack_en = 1'b1;

        // Four not-done status reads then done; err clears on new start
        poll_target = poll_seen + 4;
        lb = log_q.size(); db = done_cnt;
        pulse_start(32'd1);
        check("poll_err_cleared", 64'(err), 64'd0);
        wait_done("poll", 300);
        check("poll_nbus", 64'(log_q.size() - lb), 64'd9);
        for (int i = 0; i < 9; i++) check_bus("poll", lb, i, exp_d[i]);
        for (int i = 5; i < 9; i++)
            if (lb + i < log_cyc.size())
                check($sformatf("poll_gap%0d", i), 64'(log_cyc[lb + i] - log_cyc[lb + i - 1]), 64'd2);
        check("poll_done_err", 64'({done_cnt - db, 1'b0, err}), 64'b100);

        // Start pulsed while a sample write is on the bus is ignored
        lb = log_q.size(); db = done_cnt;
        @(negedge clk);
        start = 1'b1;
        len   = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_bus("ign", 32'h80, 1'b1, 50);
        start = 1'b1;
        len   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", 200);
        check("ign_nbus", 64'(log_q.size() - lb), 64'd7);
        for (int i = 0; i < 7; i++) check_bus("ign", lb, i, exp_e[i]);
        check("ign_done_cnt", 64'(done_cnt - db), 64'd1);
        repeat (4) @(negedge clk);
        check("ign_idle_busy", 64'(busy), 64'd0);

        // Reset asserted while the Y read is stalled on the bus
        stall_en  = 1'b1;
        stall_off = 32'h84;
        db = done_cnt;
        pulse_start(32'd1);
        wait_bus("rst", 32'h84, 1'b0, 50);
        #1 rst = 1'b1;
        #1;
        check("rst_async_cyc_stb", 64'({m_cyc_o, m_stb_o}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        stall_en = 1'b0;
        @(negedge clk);
        #1;
        check("rst_after_ctrl", 64'({busy, done, err, x_ready, y_valid, m_cyc_o, m_stb_o, m_we_o}), 64'd0);
        check("rst_after_adr_dat", {m_adr_o, m_dat_o}, 64'd0);
        check("rst_after_sel_y", 64'({m_sel_o, y_data}), 64'd0);
        check("rst_no_done", 64'(done_cnt - db), 64'd0);

        check("protocol_errors", 64'(proto_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_wb_sequencer.md
FIR_WB_SEQUENCER -- requirements
Module: fir_wb_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: FIR register-window base address.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255: maximum wait cycles per bus transfer before abort.
REQ-003 SHALL have parameter POLL_MAX, default 1023: maximum ap_done status reads before abort.
REQ-004 wb_clk_i  in  1  clock; all logic on its rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  single-cycle run request.
REQ-007 len  in  32  number of samples, sampled at accepted start.
REQ-008 busy  out  1  high from accepted start until done.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  abort flag; sticky until next accepted start.
REQ-011 x_valid / x_ready / x_data  in / out / in(32)  input-sample handshake.
REQ-012 y_valid / y_data  out / out(32)  output-sample strobe; no backpressure.
REQ-013 m_cyc_o, m_stb_o, m_we_o  out  1 each  Wishbone master controls.
REQ-014 m_sel_o  out  4;  m_adr_o  out  32;  m_dat_o  out  32  master address, data and select.
REQ-015 m_dat_i  in  32;  m_ack_i  in  1  slave read data and acknowledge.

Function
REQ-016 SHALL implement states IDLE, WR_LEN, WR_START, GET_X, WR_X, RD_Y, POLL, FINISH.
REQ-017 IDLE: start=1 SHALL be accepted, latching len and clearing err and the sample counter; start in any other state SHALL be ignored.
REQ-018 If latched len==0, SHALL go IDLE->FINISH with no bus traffic.
REQ-019 WR_LEN SHALL write len to BASE_ADDR+0x10; WR_START SHALL then write 32'h1 to BASE_ADDR+0x00.
REQ-020 GET_X SHALL drive x_ready=1 and latch x_data on x_valid&x_ready; it SHALL wait indefinitely, with no timeout.
REQ-021 WR_X SHALL write the latched sample to BASE_ADDR+0x80.
REQ-022 RD_Y SHALL read BASE_ADDR+0x84; on ack, y_data=m_dat_i and y_valid=1 for exactly the following cycle; the sample counter increments.
REQ-023 After RD_Y, SHALL go to GET_X if count<len, else to POLL.
REQ-024 POLL SHALL read BASE_ADDR+0x00 repeatedly; bit[1]=1 SHALL go to FINISH; otherwise it SHALL re-read with one idle cycle (cyc=0) between reads.
REQ-025 FINISH SHALL pulse done for one cycle, drop busy in the same cycle, then go to IDLE.
REQ-026 All m_* outputs SHALL be registered; m_sel_o=4'hF for every transfer; the master performs only single classic-cycle transfers.
REQ-027 cyc and stb SHALL rise together on the cycle after state entry and hold address, data and we stable until m_ack_i is sampled high; both SHALL fall on the following edge (minimum 2 cycles per transfer).
REQ-028 m_dat_i SHALL be captured only in the m_ack_i=1 cycle; m_ack_i SHALL be ignored while cyc=0.
REQ-029 A per-transfer counter SHALL abort when it reaches ACK_TIMEOUT cycles without ack: drop cyc/stb, set err, go to FINISH.
REQ-030 SHALL abort identically when POLL_MAX status reads complete without bit[1] set.
REQ-031 The sample counter SHALL be 32-bit; len=32'hFFFF_FFFF SHALL be supported without wrap before completion.

Reset
REQ-032 On wb_rst_i: state=IDLE; busy, done, err, x_ready, y_valid, m_cyc_o, m_stb_o, m_we_o = 0; m_adr_o, m_dat_o, m_sel_o, y_data = 0; all counters = 0.
REQ-033 Reset asserted mid-transfer SHALL drop cyc/stb immediately (asynchronously) with no done pulse.

Verification
REQ-034 len=3, samples 1,2,3, slave acks in 1 cycle and returns Y=10,20,30, status 0x2 on first poll -> bus sequence W 0x10=3, W 0x00=1, (W 0x80, R 0x84) x3, R 0x00; y_valid pulses with 10,20,30; one done pulse; err=0.
REQ-035 len=0 -> done pulses 2 cycles after start; m_cyc_o never asserts.
REQ-036 Slave never acks W 0x10 -> cyc drops after 255 wait cycles, err=1, done pulse, busy=0.
REQ-037 Status reads return 0x0 four times, then 0x2 -> exactly 5 reads of 0x00, idle cycle between each, then done.
REQ-038 start pulsed during WR_X -> ignored; len latch and transfer sequence unchanged.
REQ-039 wb_rst_i asserted while stb=1 in RD_Y -> m_cyc_o=0 in the same cycle; after release, IDLE with all outputs 0.
